// File: rtl/la_config_receiver.sv
// ---------------------------------------------------------------------------
// la_config_receiver
//
// Receives configuration packets from a UART byte stream and maintains the
// four 128-bit trigger masks of a logic analyzer. Every packet is answered
// with a one-byte acknowledgement. The only exception is a load packet that
// is abandoned because the gap between two of its bytes was too long; that
// packet sends no acknowledgement.
//
// Packet = opcode byte, then 0 or 16 payload bytes, MSB first.
//   0x01..0x04 : load trig_low / trig_high / trig_rising / trig_falling
//   0x10       : re-arm analyzer (la_reset pulse), ack 0x90
//   0x20       : ping, ack 0xA0
//   other      : ack 0xEE, no effect
//
// Parameters
//   TIMEOUT      inter-byte timeout in clk cycles while a payload is pending
//
// Ports
//   clk          single clock
//   reset_n      asynchronous active-low reset (deassertion synchronized)
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle strobe per received byte, no backpressure
//   trig_*       committed trigger masks (only ever updated atomically)
//   la_reset     one-cycle analyzer re-arm pulse
//   ack_data     response byte, held while ack_valid is high
//   ack_valid    response pending, cleared on ack_valid && ack_ready
//   ack_ready    transmitter accepts ack_data this cycle
//   overrun      sticky: a byte arrived while an ack was pending
//   timeout_err  sticky: a load packet was abandoned by timeout
// ---------------------------------------------------------------------------
module la_config_receiver #(
  parameter int TIMEOUT = 2000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] trig_low,
  output logic [127:0] trig_high,
  output logic [127:0] trig_rising,
  output logic [127:0] trig_falling,
  output logic         la_reset,
  output logic [7:0]   ack_data,
  output logic         ack_valid,
  input  logic         ack_ready,
  output logic         overrun,
  output logic         timeout_err
);

  // The counter must reach TIMEOUT-1 without wrapping.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    ACK     = 2'd2
  } state_t;

  // Reset synchronizer: reset asserts asynchronously and releases only on a
  // clock edge, so no flop sees a reset removal close to an active edge.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  state_t         state_q,        state_d;
  logic [7:0]     opcode_q,       opcode_d;
  logic [127:0]   staging_q,      staging_d;
  logic [3:0]     byte_cnt_q,     byte_cnt_d;
  logic [TW-1:0]  tmo_cnt_q,      tmo_cnt_d;
  logic [127:0]   trig_low_q,     trig_low_d;
  logic [127:0]   trig_high_q,    trig_high_d;
  logic [127:0]   trig_rising_q,  trig_rising_d;
  logic [127:0]   trig_falling_q, trig_falling_d;
  logic [7:0]     ack_data_q,     ack_data_d;
  logic           ack_valid_q,    ack_valid_d;
  logic           la_reset_q,     la_reset_d;
  logic           overrun_q,      overrun_d;
  logic           timeout_err_q,  timeout_err_d;

  // Staging value including the byte arriving this cycle. On the final
  // byte this value is written straight into the selected mask. That keeps
  // the latency at one clock, and the mask never shows a partial value.
  logic [127:0]   payload_word;
  assign payload_word = {staging_q[119:0], rx_data};

  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    staging_d      = staging_q;
    byte_cnt_d     = byte_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    trig_low_d     = trig_low_q;
    trig_high_d    = trig_high_q;
    trig_rising_d  = trig_rising_q;
    trig_falling_d = trig_falling_q;
    ack_data_d     = ack_data_q;
    ack_valid_d    = ack_valid_q;
    la_reset_d     = 1'b0;
    overrun_d      = overrun_q;
    timeout_err_d  = timeout_err_q;

    unique case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (rx_valid) begin
          unique case (rx_data)
            8'h01, 8'h02, 8'h03, 8'h04: begin
              opcode_d   = rx_data;
              byte_cnt_d = 4'd0;
              staging_d  = '0;
              state_d    = PAYLOAD;
            end
            8'h10: begin
              la_reset_d  = 1'b1;
              ack_data_d  = 8'h90;
              ack_valid_d = 1'b1;
              state_d     = ACK;
            end
            8'h20: begin
              ack_data_d  = 8'hA0;
              ack_valid_d = 1'b1;
              state_d     = ACK;
            end
            default: begin
              ack_data_d  = 8'hEE;
              ack_valid_d = 1'b1;
              state_d     = ACK;
            end
          endcase
        end
      end

      PAYLOAD: begin
        // A byte that arrives in the cycle the timeout would fire wins.
        if (rx_valid) begin
          staging_d  = payload_word;
          byte_cnt_d = byte_cnt_q + 4'd1;
          tmo_cnt_d  = '0;
          if (byte_cnt_q == 4'd15) begin
            unique case (opcode_q[2:0])
              3'd1:    trig_low_d     = payload_word;
              3'd2:    trig_high_d    = payload_word;
              3'd3:    trig_rising_d  = payload_word;
              3'd4:    trig_falling_d = payload_word;
              default: ;
            endcase
            ack_data_d  = opcode_q | 8'h80;
            ack_valid_d = 1'b1;
            state_d     = ACK;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Abandon the packet silently; the masks keep their old values.
          tmo_cnt_d     = '0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      ACK: begin
        tmo_cnt_d = '0;
        // A dropped byte and the ack acceptance can occur in the same cycle.
        // In that case both take effect.
        if (rx_valid) begin
          overrun_d = 1'b1;
        end
        if (ack_valid_q && ack_ready) begin
          ack_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      opcode_q       <= 8'h00;
      staging_q      <= '0;
      byte_cnt_q     <= 4'd0;
      tmo_cnt_q      <= '0;
      trig_low_q     <= '0;
      trig_high_q    <= '0;
      trig_rising_q  <= '0;
      trig_falling_q <= '0;
      ack_data_q     <= 8'h00;
      ack_valid_q    <= 1'b0;
      la_reset_q     <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      staging_q      <= staging_d;
      byte_cnt_q     <= byte_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      trig_low_q     <= trig_low_d;
      trig_high_q    <= trig_high_d;
      trig_rising_q  <= trig_rising_d;
      trig_falling_q <= trig_falling_d;
      ack_data_q     <= ack_data_d;
      ack_valid_q    <= ack_valid_d;
      la_reset_q     <= la_reset_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign trig_low     = trig_low_q;
  assign trig_high    = trig_high_q;
  assign trig_rising  = trig_rising_q;
  assign trig_falling = trig_falling_q;
  assign ack_data     = ack_data_q;
  assign ack_valid    = ack_valid_q;
  assign la_reset     = la_reset_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;

endmodule
